dac_sample_sender: RTL and testbench

//  Consumer end of the generator address stream: takes each 12-bit table address from

---
 rtl/dac_sample_sender.sv | 152 +++++++++++++++
 tb/tb_dac_sample_sender.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_sender.sv
// Fetches one waveform sample per accepted table address from a synchronous ROM and
// ships it MSB-first, behind a command nibble, to a serial DAC as a single SPI frame.
module dac_sample_sender #(
  parameter int unsigned ADDR_W  = 12,
  parameter logic [3:0]  CMD     = 4'b0011,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned GAP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              addr_valid,
  output logic              ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [ADDR_W-1:0] rom_data,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_mosi,
  output logic              frame_done
);

  localparam int unsigned FRAME_W  = 4 + ADDR_W;
  localparam int unsigned BIT_W    = $clog2(FRAME_W + 1);
  localparam int unsigned DIV_W    = $clog2(CLK_DIV + 1);
  localparam int unsigned WAIT_MAX = (ROM_LAT > GAP) ? ROM_LAT : GAP;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   rom_addr_d;
  logic                rom_en_d, cs_n_d, sclk_d, mosi_d, done_d;

  assign ready = (state_q == S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    div_d      = div_q;
    wait_d     = wait_q;
    rom_addr_d = rom_addr;
    rom_en_d   = 1'b0;
    cs_n_d     = dac_cs_n;
    sclk_d     = dac_sclk;
    mosi_d     = dac_mosi;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (addr_valid) begin
          rom_addr_d = address;
          rom_en_d   = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The ROM word is only guaranteed on the last wait cycle, so it is captured exactly once here.
        if (wait_q == WAIT_W'(ROM_LAT - 1)) begin
          shreg_d = {CMD, rom_data};
          state_d = S_LOAD;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_LOAD: begin
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        mosi_d  = shreg_q[FRAME_W-1];
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!dac_sclk) begin
            sclk_d = 1'b1;
          end else if (bit_q == BIT_W'(FRAME_W - 1)) begin
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            wait_d  = '0;
            state_d = S_GAP;
          end else begin
            // Data moves only on the falling SCLK edge; the DAC samples on the rise.
            sclk_d  = 1'b0;
            mosi_d  = shreg_q[FRAME_W-2];
            shreg_d = shreg_q << 1;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (wait_q == WAIT_W'(GAP - 1)) state_d = S_IDLE;
        else                            wait_d  = wait_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      wait_q     <= '0;
      rom_addr   <= '0;
      rom_en     <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      wait_q     <= wait_d;
      rom_addr   <= rom_addr_d;
      rom_en     <= rom_en_d;
      dac_cs_n   <= cs_n_d;
      dac_sclk   <= sclk_d;
      dac_mosi   <= mosi_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_dac_sample_sender.sv
// Directed bench for dac_sample_sender: default instance plus a CLK_DIV=1 / ROM_LAT=3 instance,
// each fed by a ROM model whose data is only valid in the single cycle it is meant to be sampled.
module tb_dac_sample_sender;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] address [2];
  logic        addr_valid [2];
  logic        ready [2];
  logic [11:0] rom_addr [2];
  logic        rom_en [2];
  logic [11:0] rom_data [2];
  logic        cs_n [2];
  logic        sclk [2];
  logic        mosi [2];
  logic        fd [2];

  dac_sample_sender u_dut0 (
    .clk(clk), .rst(rst), .address(address[0]), .addr_valid(addr_valid[0]), .ready(ready[0]),
    .rom_addr(rom_addr[0]), .rom_en(rom_en[0]), .rom_data(rom_data[0]), .dac_cs_n(cs_n[0]),
    .dac_sclk(sclk[0]), .dac_mosi(mosi[0]), .frame_done(fd[0])
  );

  dac_sample_sender #(.ROM_LAT(3), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .address(address[1]), .addr_valid(addr_valid[1]), .ready(ready[1]),
    .rom_addr(rom_addr[1]), .rom_en(rom_en[1]), .rom_data(rom_data[1]), .dac_cs_n(cs_n[1]),
    .dac_sclk(sclk[1]), .dac_mosi(mosi[1]), .frame_done(fd[1])
  );

  function automatic logic [11:0] rom_f(input logic [11:0] a);
    case (a)
      12'h123: rom_f = 12'hABC;
      12'h000: rom_f = 12'h000;
      12'h001: rom_f = 12'hFFF;
      default: rom_f = a ^ 12'h6C3;
    endcase
  endfunction

  // ROM models: outside the valid cycle the data bus carries noise.
  logic        en1, en2;
  logic [11:0] a1, a2;
  always @(posedge clk) begin
    rom_data[0] <= rom_en[0] ? rom_f(rom_addr[0]) : 12'($urandom);
    en1 <= rom_en[1];
    a1  <= rom_addr[1];
    en2 <= en1;
    a2  <= a1;
    rom_data[1] <= en2 ? rom_f(a2) : 12'($urandom);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observers, sampled on the falling clk edge.
  int          fd_cnt [2]        = '{0, 0};
  int          ren_cnt [2]       = '{0, 0};
  int          ready_hi [2]      = '{0, 0};
  int          frames [2]        = '{0, 0};
  int          low_run [2]       = '{0, 0};
  int          high_run [2]      = '{0, 0};
  int          rises [2]         = '{0, 0};
  int          last_low [2]      = '{0, 0};
  int          last_rises [2]    = '{0, 0};
  int          last_en_cyc [2]   = '{0, 0};
  int          first_low_cyc [2] = '{0, 0};
  int          mosi_err [2]      = '{0, 0};
  int          sclk_err [2]      = '{0, 0};
  int          min_gap [2]       = '{1000, 1000};
  logic [15:0] word [2];
  logic [15:0] last_word [2];
  logic        prev_cs [2]   = '{1'b1, 1'b1};
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  logic        prev_mosi [2] = '{1'b0, 1'b0};
  logic [15:0] word_q [$];
  logic [11:0] raddr_q [$];
  int          en_q [$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fd[i]) fd_cnt[i]++;
      if (ready[i]) ready_hi[i]++;
      if (rom_en[i]) begin
        ren_cnt[i]++;
        last_en_cyc[i] = cyc;
        if (i == 0) begin
          en_q.push_back(cyc);
          raddr_q.push_back(rom_addr[0]);
        end
      end
      if (!cs_n[i]) begin
        if (prev_cs[i]) begin
          first_low_cyc[i] = cyc;
          if (frames[i] > 0 && high_run[i] < min_gap[i]) min_gap[i] = high_run[i];
          low_run[i] = 0;
          rises[i]   = 0;
          word[i]    = '0;
        end
        low_run[i]++;
        if (sclk[i] && !prev_sclk[i]) begin
          word[i] = {word[i][14:0], mosi[i]};
          rises[i]++;
        end else if (sclk[i] && mosi[i] !== prev_mosi[i]) begin
          mosi_err[i]++;
        end
      end else begin
        if (!prev_cs[i]) begin
          frames[i]++;
          last_word[i]  = word[i];
          last_rises[i] = rises[i];
          last_low[i]   = low_run[i];
          if (i == 0) word_q.push_back(word[0]);
          high_run[i] = 0;
        end
        high_run[i]++;
        if (sclk[i]) sclk_err[i]++;
      end
      prev_cs[i]   = cs_n[i];
      prev_sclk[i] = sclk[i];
      prev_mosi[i] = mosi[i];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int s_fd, s_en, s_fr, s_hi, qw, qe, t;

  initial begin
    for (int i = 0; i < 2; i++) begin
      address[i]    = '0;
      addr_valid[i] = 1'b0;
    end

    // Reset state
    #2 rst = 1'b0;
    wait_cyc(2);
    check("rst_ready",    32'(ready[0]),    32'h1);
    check("rst_rom_en",   32'(rom_en[0]),   32'h0);
    check("rst_rom_addr", 32'(rom_addr[0]), 32'h0);
    check("rst_cs_n",     32'(cs_n[0]),     32'h1);
    check("rst_sclk",     32'(sclk[0]),     32'h0);
    check("rst_mosi",     32'(mosi[0]),     32'h0);
    check("rst_done",     32'(fd[0]),       32'h0);
    rst = 1'b1;
    wait_cyc(2);

    // Single sample 0x123 -> 0xABC, with a busy-time 0x555 pulse that must be ignored
    s_fd = fd_cnt[0]; s_en = ren_cnt[0]; s_fr = frames[0];
    address[0] = 12'h123; addr_valid[0] = 1'b1;
    wait_cyc(1);
    addr_valid[0] = 1'b0;
    wait_cyc(10);
    address[0] = 12'h555; addr_valid[0] = 1'b1;
    wait_cyc(1);
    addr_valid[0] = 1'b0;
    wait_cyc(70);
    check("single_word",     32'(last_word[0]),                   32'h3ABC);
    check("single_rises",    32'(last_rises[0]),                  32'd16);
    check("single_cs_low",   32'(last_low[0]),                    32'd64);
    check("single_latency",  32'(first_low_cyc[0] - last_en_cyc[0]), 32'd3);
    check("single_rom_addr", 32'(raddr_q[raddr_q.size()-1]),      32'h123);
    check("single_done",     32'(fd_cnt[0] - s_fd),               32'd1);
    check("busy_rom_en",     32'(ren_cnt[0] - s_en),              32'd1);
    check("busy_frames",     32'(frames[0] - s_fr),               32'd1);
    check("mosi_stable",     32'(mosi_err[0]),                    32'd0);
    check("sclk_idle_low",   32'(sclk_err[0]),                    32'd0);

    // Back-to-back 0x000, 0x001, 0x002 with addr_valid held high (also edge data 0x000 / 0xFFF)
    qw = word_q.size(); qe = en_q.size();
    addr_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      address[0] = 12'(k);
      t = 0;
      while (!ready[0] && t < 200) begin
        wait_cyc(1);
        t++;
      end
      check("b2b_ready_timeout", 32'(t < 200), 32'h1);
      wait_cyc(1);
      if (k == 0) s_hi = ready_hi[0];
    end
    addr_valid[0] = 1'b0;
    check("b2b_ready_high_cycles", 32'(ready_hi[0] - s_hi), 32'd2);
    wait_cyc(80);
    check("b2b_frames",   32'(word_q.size() - qw), 32'd3);
    check("b2b_word0",    32'(word_q[qw]),         32'h3000);
    check("b2b_word1",    32'(word_q[qw+1]),       32'h3FFF);
    check("b2b_word2",    32'(word_q[qw+2]),       32'h36C1);
    check("b2b_addr0",    32'(raddr_q[qe]),        32'h000);
    check("b2b_addr1",    32'(raddr_q[qe+1]),      32'h001);
    check("b2b_addr2",    32'(raddr_q[qe+2]),      32'h002);
    check("b2b_period01", 32'(en_q[qe+1] - en_q[qe]),   32'd70);
    check("b2b_period12", 32'(en_q[qe+2] - en_q[qe+1]), 32'd70);
    check("b2b_min_gap",  32'(min_gap[0] >= 2),    32'h1);

    // Parameter variant: CLK_DIV=1, ROM_LAT=3
    s_fd = fd_cnt[1];
    address[1] = 12'h123; addr_valid[1] = 1'b1;
    wait_cyc(1);
    addr_valid[1] = 1'b0;
    wait_cyc(50);
    check("p_word",      32'(last_word[1]),                       32'h3ABC);
    check("p_rises",     32'(last_rises[1]),                      32'd16);
    check("p_cs_low",    32'(last_low[1]),                        32'd32);
    check("p_latency",   32'(first_low_cyc[1] - last_en_cyc[1]),  32'd5);
    check("p_done",      32'(fd_cnt[1] - s_fd),                   32'd1);
    check("p_mosi",      32'(mosi_err[1]),                        32'd0);

    // Reset in the middle of a frame
    address[0] = 12'h001; addr_valid[0] = 1'b1;
    wait_cyc(1);
    addr_valid[0] = 1'b0;
    wait_cyc(30);
    check("mid_cs_low", 32'(cs_n[0]), 32'h0);
    s_fd = fd_cnt[0]; s_en = ren_cnt[0];
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_cs_n",  32'(cs_n[0]),  32'h1);
    check("abort_sclk",  32'(sclk[0]),  32'h0);
    check("abort_mosi",  32'(mosi[0]),  32'h0);
    check("abort_ready", 32'(ready[0]), 32'h1);
    check("abort_done",  32'(fd[0]),   32'h0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(80);
    check("abort_no_done",  32'(fd_cnt[0] - s_fd),  32'd0);
    check("abort_no_fetch", 32'(ren_cnt[0] - s_en), 32'd0);
    check("abort_idle_cs",  32'(cs_n[0]),           32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
